crack_job_controller: RTL and testbench

Job front-end for the brute-force password cracker. Accepts a 4-character target password as a byte stream, validates it against the 36-symbol charset (a–z, 0–9), and drives the cracker array's `password_to_crack` and reset. It measures run time until the array reports `found` or `done`, then returns a result record over a valid/ready handshake. It sits directly upstream of `password_cracker_main` and consumes that block's `found`/`done`.

---
 rtl/crack_pkg.sv | 33 +++
 rtl/crack_byte_assembler.sv | 67 ++++++
 rtl/crack_job_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_crack_job_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// -----------------------------------------------------------------------------
// crack_pkg
// Shared constants, FSM state type and charset check for the cracker job
// front-end (crack_job_controller and crack_byte_assembler).
//   PW_LEN / PW_BITS   : password length in characters / width of the target bus
//   CH_*               : inclusive bounds of the accepted charset (a-z, 0-9)
//   crack_state_e      : job FSM states
//   char_valid()       : 1 when a byte belongs to the charset
// -----------------------------------------------------------------------------
package crack_pkg;

  localparam int PW_LEN  = 4;
  localparam int PW_BITS = 33;

  localparam logic [7:0] CH_LOWER_LO = 8'h61;  // 'a'
  localparam logic [7:0] CH_LOWER_HI = 8'h7A;  // 'z'
  localparam logic [7:0] CH_DIGIT_LO = 8'h30;  // '0'
  localparam logic [7:0] CH_DIGIT_HI = 8'h39;  // '9'

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_HOLD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_REPORT  = 3'd4
  } crack_state_e;

  function automatic logic char_valid(input logic [7:0] b);
    return ((b >= CH_LOWER_LO) && (b <= CH_LOWER_HI)) ||
           ((b >= CH_DIGIT_LO) && (b <= CH_DIGIT_HI));
  endfunction

endpackage

// File: rtl/crack_byte_assembler.sv
// -----------------------------------------------------------------------------
// crack_byte_assembler
// Collects PW_LEN password bytes, first byte ending up most significant, and
// tracks whether any of them fell outside the charset.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   byte_fire     : a byte is being accepted this cycle
//   byte_data     : the byte being accepted
//   clr           : drop any partial password (index and bad flag)
//   word_next     : assembled word including the byte currently offered
//   complete      : pulse, the last byte of a password is accepted this cycle
//   complete_bad  : with complete, the finished password contains a bad byte
// -----------------------------------------------------------------------------
module crack_byte_assembler
  import crack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_fire,
  input  logic [7:0]            byte_data,
  input  logic                  clr,
  output logic [PW_LEN*8-1:0]   word_next,
  output logic                  complete,
  output logic                  complete_bad
);

  localparam int IW = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
  localparam int HW = (PW_LEN - 1) * 8;

  logic [IW-1:0] idx_q, idx_d;
  logic          bad_q, bad_d;
  // Only the earlier bytes need storage; the final byte is taken straight
  // from the input when the password completes.
  logic [HW-1:0] word_q, word_d;

  always_comb begin
    idx_d        = idx_q;
    bad_d        = bad_q;
    word_d       = word_q;
    word_next    = {word_q, byte_data};
    complete     = byte_fire && (idx_q == IW'(PW_LEN - 1));
    complete_bad = bad_q || !char_valid(byte_data);
    if (clr) begin
      idx_d = '0;
      bad_d = 1'b0;
    end else if (byte_fire) begin
      word_d = word_next[HW-1:0];
      bad_d  = complete_bad;
      idx_d  = complete ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      bad_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      bad_q <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule

// File: rtl/crack_job_controller.sv
// -----------------------------------------------------------------------------
// crack_job_controller
// Job front-end for the brute-force cracker array: takes a 4-character target
// over a byte stream, rejects jobs with characters outside a-z/0-9, resets and
// releases the array, times the run until found/done and returns a result
// record over a valid/ready handshake.
// Optional feature macro: CRACK_TIMEOUT_EN (RUN watchdog at TIMEOUT_CYCLES).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : password byte stream, leftmost char first
//   cracker_rst                   : reset to the cracker array
//   password_to_crack[32:0]       : target, first char in [31:24], bit 32 = 0
//   cracker_found/cracker_done    : array status flags
//   res_valid/res_ready           : result handshake
//   res_found/res_err/res_timeout : result flags
//   res_cycles[CW-1:0]            : run cycles counted from array release
// -----------------------------------------------------------------------------
module crack_job_controller
  import crack_pkg::*;
#(
  parameter int RST_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int CW             = 32,
  parameter int TIMEOUT_CYCLES = 1048576
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               cracker_rst,
  output logic [PW_BITS-1:0] password_to_crack,
  input  logic               cracker_found,
  input  logic               cracker_done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic               res_err,
  output logic               res_timeout,
  output logic [CW-1:0]      res_cycles
);

  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  crack_state_e          state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic [PW_BITS-1:0]    pw_q, pw_d;
  logic                  crk_rst_q, crk_rst_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_found_q, res_found_d;
  logic                  res_err_q, res_err_d;
  logic [CW-1:0]         res_cycles_q, res_cycles_d;
`ifdef CRACK_TIMEOUT_EN
  logic                  res_timeout_q, res_timeout_d;
`endif

  logic                  in_fire;
  logic                  asm_clr;
  logic [PW_LEN*8-1:0]   word_next;
  logic                  complete;
  logic                  complete_bad;

  assign in_ready = (state_q == ST_COLLECT);
  assign in_fire  = in_valid && in_ready;

  crack_byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .byte_fire    (in_fire),
    .byte_data    (in_data),
    .clr          (asm_clr),
    .word_next    (word_next),
    .complete     (complete),
    .complete_bad (complete_bad)
  );

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    pw_d         = pw_q;
    res_found_d  = res_found_q;
    res_err_d    = res_err_q;
    res_cycles_d = res_cycles_q;
`ifdef CRACK_TIMEOUT_EN
    res_timeout_d = res_timeout_q;
`endif
    asm_clr      = 1'b0;
    cnt_inc      = sat_inc(cnt_q);

    unique case (state_q)
      ST_COLLECT: begin
        if (complete) begin
          if (complete_bad) begin
            // Rejected job: report immediately, the array stays in reset.
            res_err_d    = 1'b1;
            res_found_d  = 1'b0;
            res_cycles_d = '0;
`ifdef CRACK_TIMEOUT_EN
            res_timeout_d = 1'b0;
`endif
            state_d      = ST_REPORT;
          end else begin
            pw_d    = {1'b0, word_next};
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (tmr_q == TW'(RST_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      ST_SETTLE: begin
        // Array flags may still be stale from before the reset; only count.
        cnt_d = cnt_inc;
        if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      ST_RUN: begin
        cnt_d = cnt_inc;
        // The reported count includes the terminating cycle.
        if (cracker_found || cracker_done) begin
          res_found_d  = cracker_found;
          res_err_d    = 1'b0;
          res_cycles_d = cnt_inc;
`ifdef CRACK_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          state_d      = ST_REPORT;
        end
`ifdef CRACK_TIMEOUT_EN
        else if (cnt_inc >= CW'(TIMEOUT_CYCLES)) begin
          res_found_d   = 1'b0;
          res_err_d     = 1'b0;
          res_cycles_d  = CW'(TIMEOUT_CYCLES);
          res_timeout_d = 1'b1;
          state_d       = ST_REPORT;
        end
`endif
      end

      ST_REPORT: begin
        if (res_ready) begin
          asm_clr = 1'b1;
          state_d = ST_COLLECT;
        end
      end

      default: state_d = ST_COLLECT;
    endcase

    // Registered decodes of the next state keep these outputs glitch-free.
    crk_rst_d   = !((state_d == ST_SETTLE) || (state_d == ST_RUN));
    res_valid_d = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      tmr_q        <= '0;
      cnt_q        <= '0;
      pw_q         <= '0;
      crk_rst_q    <= 1'b1;
      res_valid_q  <= 1'b0;
      res_found_q  <= 1'b0;
      res_err_q    <= 1'b0;
      res_cycles_q <= '0;
`ifdef CRACK_TIMEOUT_EN
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      pw_q         <= pw_d;
      crk_rst_q    <= crk_rst_d;
      res_valid_q  <= res_valid_d;
      res_found_q  <= res_found_d;
      res_err_q    <= res_err_d;
      res_cycles_q <= res_cycles_d;
`ifdef CRACK_TIMEOUT_EN
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  assign cracker_rst       = crk_rst_q;
  assign password_to_crack = pw_q;
  assign res_valid         = res_valid_q;
  assign res_found         = res_found_q;
  assign res_err           = res_err_q;
  assign res_cycles        = res_cycles_q;
`ifdef CRACK_TIMEOUT_EN
  assign res_timeout       = res_timeout_q;
`else
  assign res_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_crack_job_controller.sv
`timescale 1ns/1ps
module tb_crack_job_controller;

  localparam int RST_C = 2;
  localparam int SET_C = 2;
  localparam int CW    = 32;
  localparam int TO_C  = 100;
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          cracker_rst;
  logic [32:0]   password_to_crack;
  logic          cracker_found;
  logic          cracker_done;
  logic          res_valid;
  logic          res_ready;
  logic          res_found;
  logic          res_err;
  logic          res_timeout;
  logic [CW-1:0] res_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  crack_job_controller #(
    .RST_CYCLES     (RST_C),
    .SETTLE_CYCLES  (SET_C),
    .CW             (CW),
    .TIMEOUT_CYCLES (TO_C)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .cracker_rst       (cracker_rst),
    .password_to_crack (password_to_crack),
    .cracker_found     (cracker_found),
    .cracker_done      (cracker_done),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_found         (res_found),
    .res_err           (res_err),
    .res_timeout       (res_timeout),
    .res_cycles        (res_cycles)
  );

  typedef struct packed {
    bit found;
    bit err;
    bit timeout;
    int cycles;
  } res_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_charset(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h30 && c <= 8'h39);
  endfunction

  // Result predicted from the job rules: any bad char rejects the job;
  // otherwise the first cycle (counted from release) on which a held flag is
  // visible ends the run, but nothing is visible before the first
  // post-settle cycle.
  function automatic res_t predict(input logic [31:0] pw, input int tf, input int td);
    res_t r;
    int   t;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (!in_charset(pw[31-8*i -: 8])) r.err = 1'b1;
    if (r.err) return r;
    t = NEVER;
    if (tf > 0) t = tf;
    if (td > 0 && td < t) t = td;
    if (t < SET_C + 1) t = SET_C + 1;
    r.found  = (tf > 0) && (tf <= t);
    r.cycles = t;
`ifdef CRACK_TIMEOUT_EN
    if (t > TO_C) begin
      r.timeout = 1'b1;
      r.found   = 1'b0;
      r.cycles  = TO_C;
    end
`endif
    return r;
  endfunction

  function automatic logic [7:0] gen_byte();
    int idx;
    if ($urandom_range(0, 9) == 0) return 8'($urandom);
    idx = $urandom_range(0, 35);
    if (idx < 26) return 8'(8'h61 + idx);
    return 8'(8'h30 + idx - 26);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    repeat ($urandom_range(0, 2)) tick();
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_pw(input logic [31:0] pw);
    for (int i = 0; i < 4; i++) send_byte(pw[31-8*i -: 8]);
  endtask

  task automatic run_job(input logic [31:0] pw, input int tf, input int td,
                         input bit stale, input int rdy_wait);
    res_t e;
    int   lat;
    int   rel;
    bit   fin;
    e = predict(pw, tf, td);
    send_pw(pw);
    chk("busy_in_ready", in_ready, 0);
    lat = 0;
    rel = 0;
    fin = 1'b0;
    while (!fin) begin
      lat++;
      if (e.err) begin
        chk("err_rst_held", cracker_rst, 1);
        if (res_valid) begin
          chk("err_latency", lat, 1);
          fin = 1'b1;
        end
      end else begin
        if (lat == 1) chk("pw_target", password_to_crack, {1'b0, pw});
        if (!cracker_rst) begin
          if (rel == 0) chk("release_latency", lat, RST_C + 1);
          rel++;
        end else if (rel > 0) begin
          chk("res_valid_rise", res_valid, 1);
          fin = 1'b1;
        end
      end
      cracker_found = !fin && (tf > 0) && (rel >= tf);
      cracker_done  = !fin && (((td > 0) && (rel >= td)) ||
                               (stale && rel >= 1 && rel <= SET_C));
      if (!fin && lat > TO_C + 600) begin
        chk("job_budget", res_valid, 1);
        fin = 1'b1;
      end
      if (!fin) tick();
    end
    cracker_found = 1'b0;
    cracker_done  = 1'b0;
    chk("res_valid", res_valid, 1);
    chk("res_found", res_found, e.found);
    chk("res_err", res_err, e.err);
    chk("res_timeout", res_timeout, e.timeout);
    chk("res_cycles", res_cycles, e.cycles);
    for (int k = 0; k < rdy_wait; k++) begin
      res_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h61;
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_cycles", res_cycles, e.cycles);
      chk("hold_found", res_found, e.found);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_valid", res_valid, 0);
    chk("post_hs_crk_rst", cracker_rst, 1);
  endtask

  task automatic reset_in_run();
    int rel;
    int lat;
    rel = 0;
    lat = 0;
    send_pw({8'h71, 8'h77, 8'h65, 8'h72});
    while (rel < 5 && lat < 50) begin
      tick();
      lat++;
      if (!cracker_rst) rel++;
    end
    chk("rst_reach_run", rel, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_crk_rst", cracker_rst, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pw", password_to_crack, 0);
    chk("rst_cycles", res_cycles, 0);
  endtask

  logic [31:0] rpw;
  int          rtf;
  int          rtd;

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = 8'h00;
    cracker_found = 1'b0;
    cracker_done  = 1'b0;
    res_ready     = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_crk_rst", cracker_rst, 1);
    chk("reset_pw", password_to_crack, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_found", res_found, 0);
    chk("reset_res_err", res_err, 0);
    chk("reset_res_timeout", res_timeout, 0);
    chk("reset_res_cycles", res_cycles, 0);

    run_job({8'h61, 8'h62, 8'h31, 8'h32}, 50, 0, 1'b0, 10);   // "ab12"
    run_job({8'h7a, 8'h7a, 8'h39, 8'h41}, 7, 0, 1'b0, 0);     // "zz9A"
    run_job({8'h6b, 8'h30, 8'h39, 8'h7a}, 0, 30, 1'b1, 2);    // stale done
    run_job({8'h6d, 8'h6e, 8'h6f, 8'h70}, 40, 40, 1'b0, 0);   // both at once
    run_job({8'h61, 8'h61, 8'h61, 8'h61}, 1, 0, 1'b0, 1);     // held early found
    run_job({8'h2f, 8'h3a, 8'h60, 8'h7b}, 10, 0, 1'b0, 1);    // charset edges
    reset_in_run();
    run_job({8'h30, 8'h39, 8'h61, 8'h7a}, 12, 0, 1'b0, 0);
`ifdef CRACK_TIMEOUT_EN
    run_job({8'h61, 8'h31, 8'h62, 8'h32}, 0, 0, 1'b0, 3);     // silent array
    run_job({8'h63, 8'h64, 8'h65, 8'h66}, TO_C, 0, 1'b0, 0);  // found wins
`endif

    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 4; i++) rpw[31-8*i -: 8] = gen_byte();
      rtf = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 150);
      rtd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 150);
`ifndef CRACK_TIMEOUT_EN
      if (rtf == 0 && rtd == 0) rtf = $urandom_range(1, 150);
`endif
      run_job(rpw, rtf, rtd, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
